score_player: RTL and testbench

//  Parametrised successor to the fixed 3-note, 32-entry score player. Holds a writable score of
//  (Key, Duration) entries in internal registers and plays it as a square wave on Speaker.

---
 rtl/score_player.sv | 184 ++++++++++++++++++
 tb/tb_score_player.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_player.sv
// Score player: a writable register score of (key, duration) entries played back as a
// square wave, with start-address select, stop, loop, rests, end markers and inter-note gaps.
module score_player #(
  parameter int ADDR_BITS  = 5,
  parameter int KEY_BITS   = 3,
  parameter int NUM_KEYS   = 7,
  parameter int DUR_BITS   = 4,
  parameter int TICK_DIV   = 5000000,
  parameter int HALF_BASE  = 95556,
  parameter int HALF_STEP  = 10000,
  parameter int GAP_CYCLES = 500000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stop,
  input  logic                 Loop,
  input  logic [ADDR_BITS-1:0] StartAddress,
  input  logic                 WriteEnable,
  input  logic [ADDR_BITS-1:0] WriteAddress,
  input  logic [KEY_BITS-1:0]  WriteKey,
  input  logic [DUR_BITS-1:0]  WriteDuration,
  output logic                 Speaker,
  output logic                 Playing,
  output logic [ADDR_BITS-1:0] CurrentAddress,
  output logic [KEY_BITS-1:0]  CurrentKey,
  output logic                 Done
);

  localparam int DEPTH    = 2**ADDR_BITS;
  localparam int HALF_MAX = HALF_BASE + (NUM_KEYS - 1) * HALF_STEP;
  localparam int HW       = (HALF_MAX > 1) ? $clog2(HALF_MAX + 1) : 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef struct packed {
    logic [KEY_BITS-1:0] key;
    logic [DUR_BITS-1:0] dur;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

  state_t               state, nxt;
  entry_t               score [DEPTH];
  entry_t               fetched;
  logic [ADDR_BITS-1:0] start_addr;
  logic                 first;
  logic [DUR_BITS-1:0]  ticks;
  logic [PW-1:0]        presc;
  logic [HW-1:0]        half_cnt, half_last;
  logic [GW-1:0]        gap_cnt;
  logic                 rest, play_end, gap_end;
  logic                 load_start, restart_loop, adv, done_set;
  int                   half_int;

  assign fetched  = score[CurrentAddress];
  assign Playing  = (state != S_IDLE);
  assign play_end = (presc == PRESC_LAST) && (ticks == DUR_BITS'(1));
  assign gap_end  = (gap_cnt == GAP_LAST);

  // Keys outside 1..NUM_KEYS are silent; only legal keys need a meaningful half period.
  assign rest      = (CurrentKey == '0) || (int'(CurrentKey) > NUM_KEYS);
  always_comb begin
    half_int = HALF_BASE + (NUM_KEYS - int'(CurrentKey)) * HALF_STEP;
  end
  assign half_last = HW'(half_int - 1);

  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    load_start   = 1'b0;
    restart_loop = 1'b0;
    adv          = 1'b0;
    done_set     = 1'b0;
    if (Stop && state != S_IDLE) begin
      nxt = S_IDLE;
    end else if (Start && !Stop) begin
      nxt        = S_FETCH;
      load_start = 1'b1;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetched.dur != '0) begin
            nxt = S_PLAY;
          end else if (first || !Loop) begin
            // An end marker on the first fetch would loop forever, so it always finishes.
            nxt      = S_IDLE;
            done_set = 1'b1;
          end else begin
            nxt          = S_FETCH;
            restart_loop = 1'b1;
          end
        end
        S_PLAY: begin
          if (play_end) begin
            if (GAP_CYCLES == 0) begin
              nxt = S_FETCH;
              adv = 1'b1;
            end else begin
              nxt = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_end) begin
            nxt = S_FETCH;
            adv = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) score[i] <= '0;
      CurrentAddress <= '0;
      CurrentKey     <= '0;
      Speaker        <= 1'b0;
      Done           <= 1'b0;
      start_addr     <= '0;
      first          <= 1'b0;
      ticks          <= '0;
      presc          <= '0;
      half_cnt       <= '0;
      gap_cnt        <= '0;
    end else begin
      if (WriteEnable) score[WriteAddress] <= '{key: WriteKey, dur: WriteDuration};
      Done <= done_set;

      if (load_start) begin
        start_addr     <= StartAddress;
        CurrentAddress <= StartAddress;
        first          <= 1'b1;
      end else if (restart_loop) begin
        CurrentAddress <= start_addr;
        first          <= 1'b1;
      end else if (adv) begin
        CurrentAddress <= CurrentAddress + 1'b1;
      end
      if (state == S_FETCH && nxt == S_PLAY) first <= 1'b0;

      if (state == S_FETCH) begin
        CurrentKey <= fetched.key;
        ticks      <= fetched.dur;
      end

      if (state != S_PLAY) begin
        presc <= '0;
      end else if (presc == PRESC_LAST) begin
        presc <= '0;
        ticks <= ticks - 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // Speaker is forced low whenever the next cycle is not a continuing note.
      if (state == S_PLAY && nxt == S_PLAY) begin
        if (rest) begin
          Speaker <= 1'b0;
        end else if (half_cnt == half_last) begin
          half_cnt <= '0;
          Speaker  <= ~Speaker;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end else begin
        half_cnt <= '0;
        Speaker  <= 1'b0;
      end

      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_score_player.sv
// Bench for score_player: each scenario replays a trace predicted from the score rules
// (note lengths, tone periods, gaps, end markers) and compares the DUT cycle by cycle.
module tb_score_player;
  localparam int AB = 3, KB = 3, DB = 4;

  logic          Clock = 0, Reset = 0, Start = 0, Stop = 0, Loop = 0, WriteEnable = 0;
  logic [AB-1:0] StartAddress = '0, WriteAddress = '0;
  logic [KB-1:0] WriteKey = '0;
  logic [DB-1:0] WriteDuration = '0;
  logic          Speaker, Playing, Done;
  logic [AB-1:0] CurrentAddress;
  logic [KB-1:0] CurrentKey;

  int n_cmp = 0, n_bad = 0;
  int m_key [8];
  int m_dur [8];
  logic [5:0] exp_q [$];   // {speaker, playing, address, done}

  always #5 Clock = ~Clock;

  score_player #(
    .ADDR_BITS(AB), .KEY_BITS(KB), .NUM_KEYS(4), .DUR_BITS(DB), .TICK_DIV(4),
    .HALF_BASE(2), .HALF_STEP(1), .GAP_CYCLES(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Loop(Loop),
    .StartAddress(StartAddress), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteKey(WriteKey), .WriteDuration(WriteDuration), .Speaker(Speaker),
    .Playing(Playing), .CurrentAddress(CurrentAddress), .CurrentKey(CurrentKey), .Done(Done)
  );

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic write_entry(input int a, input int k, input int d);
    WriteEnable = 1; WriteAddress = AB'(a); WriteKey = KB'(k); WriteDuration = DB'(d);
    m_key[a] = k; m_dur[a] = d;
    tick();
    WriteEnable = 0;
  endtask

  task automatic load_directed();
    write_entry(0, 4, 2); write_entry(1, 1, 1); write_entry(2, 0, 0);
  endtask

  task automatic pulse_start(input int a, input bit lp);
    StartAddress = AB'(a); Loop = lp; Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic stop_pulse();
    Stop = 1;
    tick();
    Stop = 0;
  endtask

  // Expected trace from the cycle after Start is sampled (the FETCH cycle) onward.
  function automatic void build(input int start, input bit lp, input int maxlen);
    int a, d, k, half;
    bit first, fin, spk;
    a = start; first = 1; fin = 0;
    exp_q.delete();
    while (exp_q.size() < maxlen) begin
      if (fin) begin
        exp_q.push_back({1'b0, 1'b0, AB'(a), 1'b0});
      end else begin
        exp_q.push_back({1'b0, 1'b1, AB'(a), 1'b0});
        d = m_dur[a]; k = m_key[a];
        if (d == 0) begin
          if (first || !lp) begin
            exp_q.push_back({1'b0, 1'b0, AB'(a), 1'b1});
            fin = 1;
          end else begin
            a = start; first = 1;
          end
        end else begin
          first = 0;
          half = 2 + (4 - k);
          for (int i = 0; i < d * 4; i++) begin
            spk = (k >= 1 && k <= 4) ? ((i / half) % 2 == 1) : 1'b0;
            exp_q.push_back({spk, 1'b1, AB'(a), 1'b0});
          end
          repeat (2) exp_q.push_back({1'b0, 1'b1, AB'(a), 1'b0});
          a = (a + 1) % 8;
        end
      end
    end
  endfunction

  task automatic test_reset();
    repeat (2) tick();
    Reset = 1;
    write_entry(1, 3, 3); write_entry(5, 2, 1);
    Reset = 0; Start = 1; StartAddress = 3'd5;
    WriteEnable = 1; WriteAddress = 3'd6; WriteKey = 3'd7; WriteDuration = 4'd7;
    repeat (3) tick();
    @(negedge Clock);
    n_cmp++;
    if ({Speaker, Playing, Done} !== 3'b000) begin
      n_bad++; $display("FAIL reset_outputs: got spk/play/done=%b want 000", {Speaker, Playing, Done});
    end
    n_cmp++;
    if ({CurrentAddress, CurrentKey} !== 6'd0) begin
      n_bad++; $display("FAIL reset_regs: got addr=%0d key=%0d want 0/0", CurrentAddress, CurrentKey);
    end
    tick();
    Reset = 1; Start = 0; WriteEnable = 0;
    for (int i = 0; i < 8; i++) begin m_key[i] = 0; m_dur[i] = 0; end
    for (int a = 0; a < 8; a++) begin
      pulse_start(a, 0);
      build(a, 0, 3);
      for (int i = 0; i < 3; i++) begin
        @(negedge Clock);
        n_cmp++;
        if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
          n_bad++; $display("FAIL reset_entry a=%0d cyc=%0d: got %b want %b", a, i,
                            {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
        end
        if (i == 1) begin
          n_cmp++;
          if (CurrentKey !== 3'd0) begin
            n_bad++; $display("FAIL reset_entry_key a=%0d: got %0d want 0", a, CurrentKey);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_score();
    load_directed();
    pulse_start(0, 0);
    build(0, 0, 25);
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL score cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (CurrentKey !== 3'd4) begin
          n_bad++; $display("FAIL score_key: got %0d want 4", CurrentKey);
        end
      end
    end
    tick();
  endtask

  task automatic test_loop_stop();
    int dn;
    load_directed();
    pulse_start(0, 1);
    build(0, 1, 42);
    for (int i = 0; i < 42; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL loop cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
    stop_pulse();
    dn = 0;
    @(negedge Clock);
    n_cmp++;
    if ({Speaker, Playing, Done} !== 3'b000) begin
      n_bad++; $display("FAIL loop_stop: got spk/play/done=%b want 000", {Speaker, Playing, Done});
    end
    repeat (4) begin
      @(negedge Clock);
      if (Done) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin
      n_bad++; $display("FAIL loop_stop_done: got %0d Done cycles want 0", dn);
    end
    tick();
    Loop = 0;
  endtask

  task automatic test_start_stop_play();
    load_directed();
    pulse_start(0, 0);
    build(0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL ss_pre cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
    StartAddress = 3'd1; Start = 1; Stop = 1;
    tick();
    Start = 0; Stop = 0;
    @(negedge Clock);
    n_cmp++;
    if ({Speaker, Playing, Done} !== 3'b000) begin
      n_bad++; $display("FAIL start_stop: got spk/play/done=%b want 000", {Speaker, Playing, Done});
    end
    tick();
    pulse_start(0, 0);
    repeat (3) tick();
    pulse_start(1, 0);
    build(1, 0, 12);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL restart cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_write_collision();
    load_directed();
    pulse_start(0, 0);
    build(0, 0, 20);
    write_entry(0, 2, 0);   // lands on the FETCH cycle of entry 0
    for (int i = 1; i < 20; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL collide cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
    pulse_start(0, 0);
    build(0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL collide_new cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_rest();
    load_directed();
    write_entry(0, 0, 3);
    pulse_start(0, 0);
    build(0, 0, 20);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL rest cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_end_at_start();
    write_entry(3, 2, 0);
    pulse_start(3, 1);
    build(3, 1, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL end_at_start cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (CurrentKey !== 3'd2) begin
          n_bad++; $display("FAIL end_at_start_key: got %0d want 2", CurrentKey);
        end
      end
    end
    tick();
    Loop = 0;
  endtask

  task automatic test_wrap();
    for (int a = 0; a < 8; a++) write_entry(a, a % 5, 1);
    pulse_start(6, 0);
    build(6, 0, 60);
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
        n_bad++; $display("FAIL wrap cyc=%0d: got %b want %b", i,
                          {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
      end
    end
    tick();
    stop_pulse();
  endtask

  task automatic test_random();
    int s;
    bit lp;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 8; a++)
        write_entry(a, $urandom_range(0, 7),
                    ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
      s  = $urandom_range(0, 7);
      lp = 1'($urandom_range(0, 1));
      pulse_start(s, lp);
      build(s, lp, 100);
      for (int i = 0; i < 100; i++) begin
        @(negedge Clock);
        n_cmp++;
        if ({Speaker, Playing, CurrentAddress, Done} !== exp_q[i]) begin
          n_bad++; $display("FAIL random it=%0d start=%0d loop=%0d cyc=%0d: got %b want %b",
                            it, s, lp, i, {Speaker, Playing, CurrentAddress, Done}, exp_q[i]);
        end
      end
      tick();
      stop_pulse();
      @(negedge Clock);
      n_cmp++;
      if (Playing !== 1'b0) begin
        n_bad++; $display("FAIL random_stop it=%0d: got playing=%b want 0", it, Playing);
      end
      tick();
      Loop = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_score();
    test_loop_stop();
    test_start_stop_play();
    test_write_collision();
    test_rest();
    test_end_at_start();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
